// File: rtl/microwave_cook_timer.sv
// Microwave cook countdown: mm:ss BCD time, one-second prescaler, preset load,
// +30 s with saturation, pause/resume, expiry pulse and timed beep.
module microwave_cook_timer #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned MODE0_SEC = 30,
    parameter int unsigned MODE1_SEC = 60,
    parameter int unsigned MODE2_SEC = 120,
    parameter int unsigned MODE3_SEC = 300,
    parameter int unsigned BEEP_SEC  = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       add30,
    input  logic       cancel,
    output logic       timerEnd,
    output logic       running,
    output logic       beep,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SET  = 2'd1,
        ST_COOK = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned PW = (CLK_HZ > 32'd1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned BW = (BEEP_SEC > 32'd1) ? $clog2(BEEP_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 32'd1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SEC - 32'd1);

    function automatic logic [15:0] sec_to_bcd(input int unsigned sec);
        int unsigned m;
        int unsigned s;
        logic [15:0] r;
        if (sec > 32'd5999) begin
            r = 16'h9959;
        end else begin
            m = sec / 32'd60;
            s = sec % 32'd60;
            r = {4'(m / 32'd10), 4'(m % 32'd10), 4'(s / 32'd10), 4'(s % 32'd10)};
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    // Carry out of sec_tens happens when st+3 >= 6, leaving st-3
    function automatic logic [15:0] bcd_add30(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        logic       sat;
        {mt, mo, st, so} = t;
        sat = 1'b0;
        if (st >= 4'd3) begin
            st = st - 4'd3;
            if (mo == 4'd9) begin
                mo = 4'd0;
                if (mt == 4'd9) begin
                    sat = 1'b1;
                end else begin
                    mt = mt + 4'd1;
                end
            end else begin
                mo = mo + 4'd1;
            end
        end else begin
            st = st + 4'd3;
        end
        return sat ? 16'h9959 : {mt, mo, st, so};
    endfunction

    localparam logic [15:0] PRESET0 = sec_to_bcd(MODE0_SEC);
    localparam logic [15:0] PRESET1 = sec_to_bcd(MODE1_SEC);
    localparam logic [15:0] PRESET2 = sec_to_bcd(MODE2_SEC);
    localparam logic [15:0] PRESET3 = sec_to_bcd(MODE3_SEC);

    state_t          r_state, w_state_nxt;
    logic [15:0]     r_time, w_time_nxt;
    logic [PW-1:0]   r_presc, w_presc_nxt;
    logic [BW-1:0]   r_beep_cnt, w_beep_cnt_nxt;
    logic            r_start_d;
    logic            r_timer_end, r_running, r_beep;
    logic            w_timer_end_nxt, w_running_nxt, w_beep_nxt;
    logic [15:0]     w_preset;
    logic            w_start_rise;
    logic            w_tick;

    assign w_start_rise = start & ~r_start_d;
    assign w_tick       = (r_presc == PRESC_MAX);

    // Preset selection
    always_comb begin
        case (mode)
            2'd0:    w_preset = PRESET0;
            2'd1:    w_preset = PRESET1;
            2'd2:    w_preset = PRESET2;
            2'd3:    w_preset = PRESET3;
            default: w_preset = 16'h0000;
        endcase
    end

    // State register, datapath registers and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state     <= ST_IDLE;
            r_time      <= 16'h0000;
            r_presc     <= '0;
            r_beep_cnt  <= '0;
            r_start_d   <= 1'b0;
            r_timer_end <= 1'b0;
            r_running   <= 1'b0;
            r_beep      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_time      <= w_time_nxt;
            r_presc     <= w_presc_nxt;
            r_beep_cnt  <= w_beep_cnt_nxt;
            r_start_d   <= start;
            r_timer_end <= w_timer_end_nxt;
            r_running   <= w_running_nxt;
            r_beep      <= w_beep_nxt;
        end
    end

    // Next-state and datapath; on a tick with add30 the decrement is applied before the add
    always_comb begin
        w_state_nxt    = r_state;
        w_time_nxt     = r_time;
        w_presc_nxt    = r_presc;
        w_beep_cnt_nxt = r_beep_cnt;
        case (r_state)
            ST_IDLE: begin
                w_presc_nxt    = '0;
                w_beep_cnt_nxt = '0;
                if (cancel) begin
                    w_time_nxt = 16'h0000;
                end else if (w_start_rise && (w_preset != 16'h0000)) begin
                    w_time_nxt  = w_preset;
                    w_state_nxt = ST_COOK;
                end else if (add30) begin
                    w_time_nxt  = 16'h0030;
                    w_state_nxt = ST_SET;
                end else begin
                    w_time_nxt = 16'h0000;
                end
            end
            ST_SET: begin
                if (cancel) begin
                    w_time_nxt  = 16'h0000;
                    w_presc_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_time_nxt  = add30 ? bcd_add30(r_time) : r_time;
                    w_state_nxt = w_start_rise ? ST_COOK : ST_SET;
                end
            end
            ST_COOK: begin
                if (cancel) begin
                    w_time_nxt  = 16'h0000;
                    w_presc_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else if (!start) begin
                    w_time_nxt  = add30 ? bcd_add30(r_time) : r_time;
                    w_state_nxt = ST_SET;
                end else if (w_tick) begin
                    w_presc_nxt = '0;
                    if (add30) begin
                        w_time_nxt = bcd_add30(bcd_dec(r_time));
                    end else if (r_time == 16'h0001) begin
                        w_time_nxt     = 16'h0000;
                        w_beep_cnt_nxt = '0;
                        w_state_nxt    = ST_DONE;
                    end else begin
                        w_time_nxt = bcd_dec(r_time);
                    end
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                    w_time_nxt  = add30 ? bcd_add30(r_time) : r_time;
                end
            end
            ST_DONE: begin
                w_time_nxt = 16'h0000;
                if (cancel || w_start_rise) begin
                    w_presc_nxt    = '0;
                    w_beep_cnt_nxt = '0;
                    w_state_nxt    = ST_IDLE;
                end else if (w_tick) begin
                    w_presc_nxt = '0;
                    if (r_beep_cnt == BEEP_LAST) begin
                        w_beep_cnt_nxt = '0;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_beep_cnt_nxt = r_beep_cnt + BW'(1);
                    end
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_time_nxt     = 16'h0000;
                w_presc_nxt    = '0;
                w_beep_cnt_nxt = '0;
            end
        endcase
    end

    // Output decode from the next state so the flags register alongside it
    always_comb begin
        w_timer_end_nxt = (r_state == ST_COOK) && (w_state_nxt == ST_DONE);
        w_running_nxt   = (w_state_nxt == ST_COOK);
        w_beep_nxt      = (w_state_nxt == ST_DONE);
    end

    assign timerEnd = r_timer_end;
    assign running  = r_running;
    assign beep     = r_beep;
    assign min_tens = r_time[15:12];
    assign min_ones = r_time[11:8];
    assign sec_tens = r_time[7:4];
    assign sec_ones = r_time[3:0];

endmodule

// File: doc/microwave_cook_timer.md
# microwave_cook_timer

Countdown timer stage for the microwave controller. Consumes the `start` level and `mode` code from the button master, holds the remaining cook time as four BCD digits (mm:ss) for the display path, and counts down once per second while cooking. When the count reaches 00:00 it returns a one-cycle `timerEnd` pulse to the button master and raises a timed `beep` request.

## Interface
- `CLK_HZ`, 100_000_000: sys_clk cycles per one-second tick; minimum 2.
- `MODE0_SEC`, 30: preset for mode 0, in seconds, 0..5999.
- `MODE1_SEC`, 60: preset for mode 1, in seconds.
- `MODE2_SEC`, 120: preset for mode 2, in seconds.
- `MODE3_SEC`, 300: preset for mode 3, in seconds.
- `BEEP_SEC`, 3: duration of `beep` after expiry, in ticks; minimum 1.

Ports:
- `sys_clk`  in  1  system clock; all logic is on the rising edge.
- `sys_rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  cook request level from the button master.
- `mode`  in  2  preset select.
- `add30`  in  1  one-cycle pulse that adds 30 s.
- `cancel`  in  1  one-cycle pulse that clears the time and returns to IDLE.
- `timerEnd`  out  1  one-cycle pulse on expiry.
- `running`  out  1  high in COOK.
- `beep`  out  1  high in DONE.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  remaining time in BCD.

## Operation
- Reset state:
  - State is IDLE.
  - All digits are 0.
  - `timerEnd`, `running` and `beep` are 0.
  - The prescaler and the beep counter are 0.
- IDLE (time = 00:00):
  - A rising edge of `start` loads the preset selected by `mode`, converted to mm:ss BCD, and enters COOK.
  - If the preset is 0, the block stays in IDLE.
  - `add30` loads 00:30 and enters SET.
- SET (time > 0, not counting):
  - A rising edge of `start` enters COOK; the current time is kept and the preset is not loaded.
  - `add30` adds 30 s.
  - `cancel` clears the time and enters IDLE.
- COOK:
  - The prescaler counts 0..CLK_HZ-1. On wrap, the time decrements by 1 s.
  - BCD borrow rules:
    - `sec_ones` goes 0 -> 9 and borrows from `sec_tens`.
    - `sec_tens` goes 0 -> 5 and borrows from `min_ones`.
    - `min_ones` goes 0 -> 9 and borrows from `min_tens`.
  - A decrement from 00:01 to 00:00 asserts `timerEnd` for exactly that cycle and enters DONE.
  - `start` low enters SET (pause). The time is held and the prescaler is kept, not cleared.
  - `add30` adds 30 s without disturbing the prescaler.
  - `cancel` clears the time and enters IDLE.
- DONE:
  - `beep` is high; the beep counter advances on each prescaler wrap.
  - After BEEP_SEC ticks, the block enters IDLE.
  - `cancel` or a rising edge of `start` exits to IDLE immediately.
  - `add30` is ignored.
- Add 30 s:
  - Performed as BCD addition with carries into minutes.
  - Saturates at 99:59; the result never wraps.
- Simultaneous events:
  - `cancel` has priority over everything else.
  - In COOK, if `add30` coincides with a tick, the result is the old time + 30 − 1 s, saturating at 99:59.
  - A tick at 00:01 together with `add30` gives 00:30 and no expiry.
- The `start` edge detector uses a registered copy of `start`. That copy resets to 0, so a `start` that is high out of reset counts as a rising edge.
- Presets above 5999 are clamped to 99:59.

## Timing
- Outputs are registered. Digits and `running` reflect a state change on the cycle after the causing input.
- First tick after entering COOK from IDLE:
  - The prescaler clears on entry.
  - The first decrement occurs CLK_HZ cycles after the cycle in which the new state is visible.
- After resuming from SET, the remaining partial second is preserved.
- `timerEnd` is high for 1 cycle only, coincident with the digits first reading 00:00 and `beep` first going high.
- Expiry to IDLE takes BEEP_SEC×CLK_HZ cycles, ±1 cycle.
- Reset mid-operation:
  - Asynchronously forces all outputs to 0.
  - No `timerEnd` pulse is generated.

## Test plan
Test parameters: CLK_HZ=10, BEEP_SEC=3.
- Mode preset: reset, `mode`=0, `start` high → digits 0,0,3,0, `running`=1. Digits read 00:29 after 10 cycles and 00:00 after 300, with one `timerEnd` pulse and `beep` high for 30 cycles, then IDLE.
- BCD borrow: `mode`=1 (01:00), one tick → 00:59. `mode`=3 with 10 `add30` pulses during COOK → 10:00, then one tick → 09:59.
- Pause/resume: `start` low 5 cycles into COOK from 00:30 → SET, digits frozen at 00:30 for 100 cycles. `start` high → next decrement after 5 more cycles.
- Saturation: time at 99:45 in SET, `add30` → 99:59. Another `add30` → still 99:59.
- Priority and coincidence: `cancel` and `add30` in the same cycle → IDLE, 00:00. At 00:01, a tick together with `add30` → 00:30 and `timerEnd` stays 0.
- Reset mid-COOK at 00:17: assert `sys_rst` low asynchronously, between clock edges → all outputs 0 immediately. After release with `start` low → remains in IDLE.
